// File: rtl/seg7_scan_decoder.sv
// Snoops a time-multiplexed, active-low 7-segment bus and reconstructs the
// hex nibble shown on each digit position. Each sample is taken once per
// stable strobe window, and a digit commits only after it has decoded to
// the same value on MATCH consecutive samples.
module seg7_scan_decoder #(
    parameter int NDIG   = 4,
    parameter int SETTLE = 3,
    parameter int MATCH  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_n,
    input  logic [NDIG-1:0]     an_n,
    input  logic                clr_err,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     dig_valid,
    output logic [NDIG-1:0]     dig_blank,
    output logic                upd,
    output logic [2:0]          upd_idx,
    output logic                code_err,
    output logic                strobe_err
);

    // Returns {decodable, blank, nibble}; a blank digit records nibble 0.
    function automatic logic [5:0] f_decode(input logic [6:0] seg);
        logic [5:0] res;
        case (seg)
            7'h40:   res = 6'b10_0000;
            7'h79:   res = 6'b10_0001;
            7'h24:   res = 6'b10_0010;
            7'h30:   res = 6'b10_0011;
            7'h19:   res = 6'b10_0100;
            7'h12:   res = 6'b10_0101;
            7'h02:   res = 6'b10_0110;
            7'h78:   res = 6'b10_0111;
            7'h00:   res = 6'b10_1000;
            7'h18:   res = 6'b10_1001;
            7'h08:   res = 6'b10_1010;
            7'h03:   res = 6'b10_1011;
            7'h46:   res = 6'b10_1100;
            7'h21:   res = 6'b10_1101;
            7'h06:   res = 6'b10_1110;
            7'h0E:   res = 6'b10_1111;
            7'h7F:   res = 6'b11_0000;
            default: res = 6'b00_0000;
        endcase
        return res;
    endfunction

    logic [NDIG-1:0]   r_an_prev;
    logic [3:0]        r_settle;
    logic [4:0]        r_cand [NDIG];
    logic [2:0]        r_mcnt [NDIG];
    logic              r_cm_vld;
    logic [2:0]        r_cm_idx;
    logic [4:0]        r_cm_val;
    logic [4*NDIG-1:0] r_digits;
    logic [NDIG-1:0]   r_dig_valid;
    logic [NDIG-1:0]   r_dig_blank;
    logic              r_upd;
    logic [2:0]        r_upd_idx;
    logic              r_code_err;
    logic              r_strobe_err;

    logic              w_an_chg;
    logic [3:0]        w_settle_nxt;
    logic              w_sample;
    logic [NDIG-1:0]   w_low;
    logic              w_idle;
    logic              w_multi;
    logic              w_one;
    logic [2:0]        w_idx;
    logic [5:0]        w_dec;
    logic [4:0]        w_cand_sel;
    logic [2:0]        w_mcnt_sel;
    logic              w_hit;
    logic [2:0]        w_cnt_new;
    logic              w_commit;

    assign w_an_chg     = (an_n != r_an_prev);
    assign w_settle_nxt = w_an_chg ? 4'd1 :
                          (r_settle < 4'(SETTLE)) ? r_settle + 4'd1 : r_settle;
    // A window yields one sample: when the counter first lands on SETTLE.
    // A change edge counts as a fresh arrival so SETTLE=1 still samples.
    assign w_sample     = (w_settle_nxt == 4'(SETTLE)) &&
                          (w_an_chg || (r_settle != 4'(SETTLE)));
    assign w_low        = ~an_n;
    assign w_idle       = (w_low == '0);
    assign w_multi      = |(w_low & (w_low - {{(NDIG-1){1'b0}}, 1'b1}));
    assign w_one        = w_sample && !w_idle && !w_multi;
    assign w_dec        = f_decode(seg_n);

    // Encode the strobed digit and fetch its candidate state.
    always_comb begin
        w_idx      = 3'd0;
        w_cand_sel = 5'd0;
        w_mcnt_sel = 3'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (w_low[i]) begin
                w_idx      = 3'(i);
                w_cand_sel = r_cand[i];
                w_mcnt_sel = r_mcnt[i];
            end
        end
    end

    assign w_hit     = (w_mcnt_sel != 3'd0) && (w_cand_sel == w_dec[4:0]);
    assign w_cnt_new = !w_dec[5] ? 3'd0 :
                       !w_hit    ? 3'd1 :
                       (w_mcnt_sel < 3'(MATCH)) ? w_mcnt_sel + 3'd1 : w_mcnt_sel;
    assign w_commit  = w_one && w_dec[5] &&
                       ((MATCH == 1) ||
                        ((w_cnt_new == 3'(MATCH)) && (w_mcnt_sel != 3'(MATCH))));

    // Strobe history and settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_prev <= '1;
            r_settle  <= 4'd0;
        end else begin
            r_an_prev <= an_n;
            r_settle  <= w_settle_nxt;
        end
    end

    // Per-digit candidate tracking; an undecodable sample empties the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NDIG; i++) begin
                r_cand[i] <= 5'd0;
                r_mcnt[i] <= 3'd0;
            end
        end else if (w_one) begin
            for (int i = 0; i < NDIG; i++) begin
                if (w_idx == 3'(i)) begin
                    r_cand[i] <= w_dec[5] ? w_dec[4:0] : 5'd0;
                    r_mcnt[i] <= w_cnt_new;
                end
            end
        end
    end

    // Pending commit, applied to the outputs on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cm_vld <= 1'b0;
            r_cm_idx <= 3'd0;
            r_cm_val <= 5'd0;
        end else begin
            r_cm_vld <= w_commit;
            if (w_commit) begin
                r_cm_idx <= w_idx;
                r_cm_val <= w_dec[4:0];
            end
        end
    end

    // Committed digit registers; upd only fires on a first or changed value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits    <= '0;
            r_dig_valid <= '0;
            r_dig_blank <= '0;
            r_upd       <= 1'b0;
            r_upd_idx   <= 3'd0;
        end else begin
            r_upd <= 1'b0;
            if (r_cm_vld) begin
                r_upd_idx <= r_cm_idx;
                for (int i = 0; i < NDIG; i++) begin
                    if (r_cm_idx == 3'(i)) begin
                        if (!r_dig_valid[i] || (r_digits[4*i +: 4] != r_cm_val[3:0]) ||
                            (r_dig_blank[i] != r_cm_val[4])) begin
                            r_upd <= 1'b1;
                        end
                        r_digits[4*i +: 4] <= r_cm_val[3:0];
                        r_dig_blank[i]     <= r_cm_val[4];
                        r_dig_valid[i]     <= 1'b1;
                    end
                end
            end
        end
    end

    // Sticky error flags; a new error outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code_err   <= 1'b0;
            r_strobe_err <= 1'b0;
        end else begin
            if (w_one && !w_dec[5]) r_code_err <= 1'b1;
            else if (clr_err)       r_code_err <= 1'b0;
            if (w_sample && w_multi) r_strobe_err <= 1'b1;
            else if (clr_err)        r_strobe_err <= 1'b0;
        end
    end

    assign digits     = r_digits;
    assign dig_valid  = r_dig_valid;
    assign dig_blank  = r_dig_blank;
    assign upd        = r_upd;
    assign upd_idx    = r_upd_idx;
    assign code_err   = r_code_err;
    assign strobe_err = r_strobe_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with NDIG=4, SETTLE=3, MATCH=2.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        clr_err;
    logic [15:0] digits;
    logic [3:0]  dig_valid;
    logic [3:0]  dig_blank;
    logic        upd;
    logic [2:0]  upd_idx;
    logic        code_err;
    logic        strobe_err;

    int n_total = 0;
    int n_pass  = 0;
    int upd_cnt = 0;
    int ucnt0   = 0;
    logic [2:0] last_idx = 3'd7;

    localparam logic [6:0] S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S5 = 7'h12, S7 = 7'h78;
    localparam logic [6:0] SA = 7'h08, SF = 7'h0E, SBL = 7'h7F, SBAD = 7'h55;

    seg7_scan_decoder #(.NDIG(4), .SETTLE(3), .MATCH(2)) dut (
        .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n), .clr_err(clr_err),
        .digits(digits), .dig_valid(dig_valid), .dig_blank(dig_blank),
        .upd(upd), .upd_idx(upd_idx), .code_err(code_err), .strobe_err(strobe_err)
    );

    always #5 clk = ~clk;

    // Count upd pulses shortly after each active edge.
    always @(posedge clk) begin
        #1;
        if (upd) begin
            upd_cnt++;
            last_idx = upd_idx;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs at n consecutive falling edges.
    task automatic drv(input logic [3:0] an, input logic [6:0] seg, input int n,
                       input logic clr = 1'b0);
        repeat (n) begin
            @(negedge clk);
            an_n    = an;
            seg_n   = seg;
            clr_err = clr;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {5'd0, digits, dig_valid, dig_blank, upd, code_err, strobe_err},
            32'h0);
    endtask

    initial begin
        rst_n = 1'b0; an_n = 4'hF; seg_n = SBL; clr_err = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset_hold");
        rst_n = 1'b1;
        drv(4'hF, SBL, 2);
        chk_zero("reset_release");

        // Single digit: first window only loads the candidate
        drv(4'hE, S2, 6);
        drv(4'hF, SBL, 4);
        chk("single_no_commit_valid", 32'(dig_valid), 32'h0);
        chk("single_no_commit_upd", 32'(upd_cnt), 32'd0);
        drv(4'hE, S2, 3);
        drv(4'hE, S2, 1);
        chk("single_sample_edge_upd", 32'(upd), 32'd0);
        drv(4'hE, S2, 1);
        chk("single_commit", {8'd0, digits, dig_valid, upd, upd_idx},
            {8'd0, 16'h0002, 4'b0001, 1'b1, 3'd0});
        drv(4'hE, S2, 2);
        chk("single_upd_one_cycle", 32'(upd), 32'd0);
        drv(4'hF, SBL, 2);
        chk("single_upd_count", 32'(upd_cnt), 32'd1);

        // Full scan, two passes then an identical third
        ucnt0 = upd_cnt;
        repeat (2) begin
            drv(4'h7, S1, 5); drv(4'hB, SA, 5); drv(4'hD, S3, 5); drv(4'hE, SF, 5);
        end
        drv(4'hF, SBL, 4);
        chk("scan_digits", 32'(digits), 32'h1A3F);
        chk("scan_valid", 32'(dig_valid), 32'hF);
        chk("scan_upd_count", 32'(upd_cnt - ucnt0), 32'd4);
        ucnt0 = upd_cnt;
        drv(4'h7, S1, 5); drv(4'hB, SA, 5); drv(4'hD, S3, 5); drv(4'hE, SF, 5);
        drv(4'hF, SBL, 4);
        chk("scan_repeat_no_upd", 32'(upd_cnt - ucnt0), 32'd0);
        chk("scan_repeat_digits", 32'(digits), 32'h1A3F);

        // Blank on digit 2
        ucnt0 = upd_cnt;
        drv(4'hB, SBL, 5); drv(4'hF, SBL, 3);
        drv(4'hB, SBL, 5); drv(4'hF, SBL, 3);
        chk("blank_mask", 32'(dig_blank), 32'b0100);
        chk("blank_digits", 32'(digits), 32'h103F);
        chk("blank_upd_count", 32'(upd_cnt - ucnt0), 32'd1);
        chk("blank_upd_idx", 32'(last_idx), 32'd2);

        // Undecodable pattern on digit 1
        drv(4'hD, SBAD, 5); drv(4'hF, SBL, 2);
        chk("code_err_set", {30'd0, code_err, strobe_err}, 32'b10);
        chk("code_err_keeps_digit", 32'(digits), 32'h103F);

        // Multi-hot strobe; clear on the sample edge loses to the set
        drv(4'hC, SBL, 2);
        drv(4'hC, SBL, 1, 1'b1);
        drv(4'hF, SBL, 1);
        chk("strobe_set_wins", {30'd0, code_err, strobe_err}, 32'b01);
        drv(4'hF, SBL, 1, 1'b1);
        drv(4'hF, SBL, 1);
        chk("clr_err_both", {30'd0, code_err, strobe_err}, 32'b00);

        // Glitch: 2-cycle strobe on digit 1 never samples; digit 0 needs 3 cycles
        drv(4'hD, S5, 2); drv(4'hE, S7, 3); drv(4'hF, SBL, 3);
        drv(4'hD, S5, 2); drv(4'hE, S7, 3);
        drv(4'hF, SBL, 1);
        chk("glitch_sample_edge", {15'd0, digits, upd}, {15'd0, 16'h103F, 1'b0});
        drv(4'hF, SBL, 1);
        chk("glitch_commit", {12'd0, digits, upd, upd_idx},
            {12'd0, 16'h1037, 1'b1, 3'd0});
        drv(4'hD, S5, 2); drv(4'hF, SBL, 2);
        chk("glitch_digit1_kept", 32'(digits[7:4]), 32'h3);

        // Reset in the middle of activity with no clock edge during the pulse
        drv(4'hC, SBL, 4);
        drv(4'hE, S2, 2);
        chk("pre_reset_strobe_err", 32'(strobe_err), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_zero("midreset_hold");
        #1 rst_n = 1'b1;
        drv(4'hE, S2, 1);
        chk_zero("midreset_release");
        drv(4'hE, S2, 4); drv(4'hF, SBL, 3);
        drv(4'hE, S2, 5); drv(4'hF, SBL, 2);
        chk("post_reset_commit", {12'd0, digits, dig_valid}, {12'd0, 16'h0002, 4'b0001});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reverse path of the team's 7-segment display path. Monitors a time-multiplexed, active-low 7-segment bus: segment lines seg_n plus per-digit anode strobes an_n.
- Reconstructs the displayed hex nibble for each digit position and qualifies each value with settle and repeat-match filtering.
- Used for display loopback self-test and for capturing front-panel readings into the datapath.

Parameters:
NDIG, 4, number of multiplexed digit positions (2..8)
SETTLE, 3, consecutive cycles an_n must hold before one sample is taken (1..15)
MATCH, 2, consecutive identical decodes of one digit required before commit (1..7)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
seg_n  in  7  segment lines {g,f,e,d,c,b,a}, bit6=g, active-low; synchronous to clk
an_n  in  NDIG  digit strobes, active-low, one-hot-low when driving; synchronous to clk
clr_err  in  1  clears sticky error flags
digits  out  4*NDIG  committed nibbles; digit i in [4i+3:4i]
dig_valid  out  NDIG  digit i has committed at least once since reset
dig_blank  out  NDIG  committed value of digit i is blank
upd  out  1  one-cycle pulse when any committed digit changes
upd_idx  out  3  index of the digit committed with upd; valid only while upd=1
code_err  out  1  sticky: undecodable segment pattern sampled
strobe_err  out  1  sticky: multi-hot an_n reached the sample point

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-low.
- Reset state, applied immediately on rst_n low:
  - all outputs 0;
  - internal an_n history = all ones, settle counter = 0;
  - all candidates empty, match counters 0.
- Inputs are assumed synchronous to clk. No synchronizers are inside the block.
- Settle tracking:
  - Any edge where an_n differs from its value at the previous edge resets the settle counter to 1. Otherwise the counter increments, saturating at SETTLE.
  - The sample edge is the edge where the counter becomes SETTLE. There is exactly one sample per stable window.
  - At the sample edge:
    - all ones (idle): no action;
    - exactly one bit low: sample that digit;
    - more than one bit low: no sample, set strobe_err.
- Decode table, seg_n to nibble:
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7
  - 0000000=8, 0011000=9, 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F
  - 1111111 = blank; nibble is recorded as 0.
  - Every other pattern: set code_err, clear the digit's candidate and reset its match counter to 0. Nothing is committed.
- Candidate per digit:
  - A sample equal to the candidate ({nibble, blank}) increments the match counter, saturating at MATCH.
  - A different sample replaces the candidate and sets the counter to 1.
  - Commit happens on the edge the counter reaches MATCH. A later saturated repeat does not re-commit.
- Commit timing and update:
  - Commit outputs (digits slice, dig_blank bit, dig_valid bit, upd, upd_idx) update one edge after the sample edge.
  - upd pulses only if dig_valid was 0 or the committed {nibble, blank} changed.
  - Scan order is irrelevant. At most one sample occurs per edge, so commits never collide.
- With MATCH=1, every valid sample commits.
- Errors:
  - code_err and strobe_err stay set until clr_err=1 at an edge.
  - If clr_err and a new error occur on the same edge, the set wins.
- Reset mid-window: all state is discarded. The first post-reset window begins counting from the first an_n edge seen after release.
- SETTLE counter wrap is not possible (saturating).

Test Plan:
- Reset values (NDIG=4, SETTLE=3, MATCH=2): pulse rst_n low mid-operation, with no clock edge during the pulse -> digits=16'h0000, dig_valid=0, dig_blank=0, upd=0, both errors=0 during reset and after release.
- Single digit:
  - Stimulus: an_n=1110, seg_n=0100100 for 6 cycles; an_n=1111 for 4 cycles; then repeat the first window.
  - Required: no commit after the first window. The second window commits digits[3:0]=2, dig_valid=0001, and one upd pulse with upd_idx=0, on the edge after the sample edge.
- Full scan:
  - Stimulus: two scan passes with digit3=1111001, digit2=0001000, digit1=0110000, digit0=0001110.
  - Required: digits=16'h1A3F, dig_valid=4'hF, exactly 4 upd pulses. A third identical pass gives no upd.
- Blank and change:
  - Stimulus: after the full scan, drive digit2 with 1111111 for two windows.
  - Required: dig_blank=0100, digits[11:8]=0, one upd with upd_idx=2.
- Errors:
  - Code: seg_n=1010101 on digit1 -> code_err=1; digit1's previous commit is unchanged.
  - Strobe: an_n=1100 held 3 cycles -> strobe_err=1.
  - Clear: clr_err for 1 cycle -> both 0.
- Glitch: an_n=1101 held 2 cycles, then 1110 -> no sample for digit1. Digit0 is sampled only after 3 stable cycles.
